// File: rtl/sweep_controller.sv
// Sweep sequencer for the regfile/ALU datapath: walks rs1 over [startAddr..endAddr]
// (wrapping mod 32), pacing each element with a programmable idle delay.
module sweep_controller #(
  parameter int DELAY_CYCLES  = 4,
  parameter int DELAY_W       = 27,
  parameter bit STOP_ON_CARRY = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic [3:0] opSel,
  input  logic [4:0] startAddr,
  input  logic [4:0] endAddr,
  input  logic       carryOut,
  output logic [4:0] rs1,
  output logic [4:0] rs2,
  output logic [4:0] rd,
  output logic [3:0] aluOp,
  output logic       regWrite,
  output logic       busy,
  output logic       done,
  output logic       carryStop,
  output logic [5:0] writeCnt,
  output logic [2:0] dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_READ  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // A zero delay still spends one cycle in WAIT, so both 0 and 1 reload to 0.
  localparam logic [DELAY_W-1:0] DLY_RELOAD =
    (DELAY_CYCLES > 0) ? DELAY_W'(DELAY_CYCLES - 1) : '0;

  state_t             r_state;
  logic [DELAY_W-1:0] r_dly;
  logic [4:0]         r_end_addr;
  logic               w_wr_ok;

  assign rs2       = rs1 + 5'd1;
  assign rd        = rs2;
  assign w_wr_ok   = (rd != 5'd0);
  assign regWrite  = (r_state == S_WRITE) && w_wr_ok && !abort;
  assign dbg_state = r_state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_dly      <= '0;
      r_end_addr <= '0;
      rs1        <= '0;
      aluOp      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      carryStop  <= 1'b0;
      writeCnt   <= '0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start && !abort) begin
            aluOp      <= opSel;
            rs1        <= startAddr;
            r_end_addr <= endAddr;
            writeCnt   <= '0;
            carryStop  <= 1'b0;
            r_dly      <= DLY_RELOAD;
            busy       <= 1'b1;
            r_state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (abort) begin
            done    <= 1'b1;
            r_state <= S_DONE;
          end else if (r_dly == '0) begin
            r_state <= S_READ;
          end else begin
            r_dly <= r_dly - DELAY_W'(1);
          end
        end
        S_READ: begin
          if (abort) begin
            done    <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_state <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (abort) begin
            done    <= 1'b1;
            r_state <= S_DONE;
          end else begin
            if (w_wr_ok) writeCnt <= writeCnt + 6'd1;
            // End of range wins over carry: the last element never sets carryStop.
            if (rs1 == r_end_addr) begin
              done    <= 1'b1;
              r_state <= S_DONE;
            end else if (STOP_ON_CARRY && carryOut) begin
              carryStop <= 1'b1;
              done      <= 1'b1;
              r_state   <= S_DONE;
            end else begin
              rs1     <= rs1 + 5'd1;
              r_dly   <= DLY_RELOAD;
              r_state <= S_WAIT;
            end
          end
        end
        S_DONE: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
